// File: rtl/axis_gen_pkg.sv
// Shared definitions for the AXI4-Stream test-pattern generator.
//   - pattern mode encodings
//   - FSM state enum
//   - 32-bit lane width and the LFSR feedback polynomial, plus its step function
package axis_gen_pkg;

  localparam int LANE_W = 32;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form: the shifted-out
  // bit is folded back into bits 31, 21, 1 and 0.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [1:0] MODE_COUNT = 2'd0;  // word = beat count
  localparam logic [1:0] MODE_LANE  = 2'd1;  // word = {beat[23:0], lane}
  localparam logic [1:0] MODE_LFSR  = 2'd2;  // every word = LFSR value
  localparam logic [1:0] MODE_WALK  = 2'd3;  // walking one across the beat

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } gen_state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/axis_gen_pattern.sv
// Beat-data generator. Holds the global beat count b and the LFSR and
// presents the registered beat for the current b.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        restart: b = 0, LFSR = LFSR_SEED, data = beat 0
//   advance     step b and the LFSR, data = next beat (ignored while load)
//   mode        pattern mode used for the beat being computed
//   data        registered DATA_WIDTH beat; holds when neither load nor advance
module axis_gen_pattern
  import axis_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int LANES = DATA_WIDTH / LANE_W;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic [31:0]           beat_q, beat_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [IDX_W-1:0]      walk_pos;

  always_comb begin
    beat_d = beat_q;
    lfsr_d = lfsr_q;
    if (load) begin
      beat_d = '0;
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      beat_d = beat_q + 32'd1;
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // The beat is computed from the *next* b/LFSR so the register already
  // holds the value that belongs to the beat now being presented.
  always_comb begin
    data_d   = '0;
    walk_pos = IDX_W'(beat_d % 32'(DATA_WIDTH));
    case (mode)
      MODE_COUNT: for (int i = 0; i < LANES; i++) data_d[i*LANE_W +: LANE_W] = beat_d;
      MODE_LANE:  for (int i = 0; i < LANES; i++) data_d[i*LANE_W +: LANE_W] = {beat_d[23:0], 8'(i)};
      MODE_LFSR:  for (int i = 0; i < LANES; i++) data_d[i*LANE_W +: LANE_W] = lfsr_d;
      default:    data_d[walk_pos] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      lfsr_q <= LFSR_SEED;
      data   <= '0;
    end else if (load || advance) begin
      beat_q <= beat_d;
      lfsr_q <= lfsr_d;
      data   <= data_d;
    end
  end

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream test-pattern source with run-time packet length, packet
// count, inter-packet gap and pattern mode, under start/abort control.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse, accepted only in IDLE; latches config
//   abort            level; run stops at the next tlast handshake or in GAP
//   mode/pkt_len/pkt_count/gap  run configuration (pkt_len 0 = 1 beat,
//                    pkt_count 0 = continuous)
//   busy, done       run in progress / one-cycle end-of-run pulse
//   pkts_sent        packets completed this run
//   m_axis_*         stream master; tkeep constant all-ones
// Handshake: a beat transfers on a cycle where tvalid && tready. Once
// tvalid is high it stays high, with tdata/tlast unchanged, until that
// transfer happens. Every output comes from a register; tready only feeds
// next-state logic.
module axis_pattern_generator
  import axis_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          LEN_WIDTH  = 16,
  parameter int          CNT_WIDTH  = 16,
  parameter int          GAP_WIDTH  = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  pkt_count,
  input  logic [GAP_WIDTH-1:0]  gap,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkts_sent,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  gen_state_e           state_q, state_d;
  logic [1:0]           mode_q;
  logic [LEN_WIDTH-1:0] last_beat_q, beat_q, beat_nxt;
  logic [CNT_WIDTH-1:0] count_q, sent_q;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt_q;
  logic                 tlast_q, done_q;
  logic                 hs, load, run_end;

  assign hs       = (state_q == S_SEND) && m_axis_tready;
  assign load     = (state_q == S_IDLE) && start;
  assign beat_nxt = beat_q + LEN_WIDTH'(1);
  assign run_end  = ((count_q != '0) && ((sent_q + CNT_WIDTH'(1)) == count_q)) || abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SEND;
      S_SEND: begin
        if (hs && tlast_q) begin
          if (run_end)          state_d = S_IDLE;
          else if (gap_q != '0) state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (abort)                               state_d = S_IDLE;
        else if (gap_cnt_q == GAP_WIDTH'(1))     state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    m_axis_tvalid = (state_q == S_SEND);
    busy          = (state_q != S_IDLE);
  end

  // Counters, latched configuration and registered tlast/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= '0;
      last_beat_q <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      beat_q      <= '0;
      sent_q      <= '0;
      gap_cnt_q   <= '0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q != S_IDLE) && (state_d == S_IDLE);
      if (load) begin
        mode_q      <= mode;
        last_beat_q <= (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
        count_q     <= pkt_count;
        gap_q       <= gap;
        beat_q      <= '0;
        sent_q      <= '0;
        tlast_q     <= (pkt_len <= LEN_WIDTH'(1));
      end else if (hs) begin
        if (tlast_q) begin
          beat_q    <= '0;
          sent_q    <= sent_q + CNT_WIDTH'(1);
          tlast_q   <= (last_beat_q == '0);
          gap_cnt_q <= gap_q;
        end else begin
          beat_q  <= beat_nxt;
          tlast_q <= (beat_nxt == last_beat_q);
        end
      end else if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
      end
    end
  end

  assign done         = done_q;
  assign pkts_sent    = sent_q;
  assign m_axis_tlast = tlast_q;
  assign m_axis_tkeep = '1;

  // At start the latched mode is not yet valid, so use the live input.
  axis_gen_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_SEED  (LFSR_SEED)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (hs),
    .mode    (load ? mode : mode_q),
    .data    (m_axis_tdata)
  );

endmodule
